// File: rtl/regread_scoreboard.sv
// Decode-side register read stage: GPR operand fetch with writeback bypass,
// a counting scoreboard for RAW/structural hazards, and the ID/EX register.
module regread_scoreboard #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned AW   = 5,
    parameter int unsigned CNTW = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pipe_go,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs1,
    input  logic [AW-1:0]   id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_wr_rd,
    input  logic            id_flush,
    output logic            id_ready,
    output logic [AW-1:0]   rf_raddr1,
    output logic [AW-1:0]   rf_raddr2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    input  logic            wb_active,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_rdval,
    input  logic            ex_ready,
    output logic            idex_valid,
    output logic [XLEN-1:0] idex_rs1_val,
    output logic [XLEN-1:0] idex_rs2_val,
    output logic [AW-1:0]   idex_rd,
    output logic            idex_wr_rd
);
    localparam int unsigned NREG = 1 << AW;
    localparam logic [CNTW-1:0] ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] FULL = '1;

    logic [CNTW-1:0] cnt [NREG];
    logic [NREG-1:0] ret;
    logic [NREG-1:0] inc;
    logic            haz1, haz2, haz_struct, issue;
    logic [XLEN-1:0] op1, op2;

    assign rf_raddr1 = id_rs1;
    assign rf_raddr2 = id_rs2;
    assign id_ready  = issue;

    always_comb begin
        ret = '0;
        if (pipe_go && wb_active && wb_rd != '0) ret[wb_rd] = 1'b1;
    end

    // A single pending write that retires this cycle is not a hazard: it is bypassed.
    always_comb begin
        haz1 = id_use_rs1 && id_rs1 != '0 &&
               (cnt[id_rs1] > ONE || (cnt[id_rs1] == ONE && !ret[id_rs1]));
        haz2 = id_use_rs2 && id_rs2 != '0 &&
               (cnt[id_rs2] > ONE || (cnt[id_rs2] == ONE && !ret[id_rs2]));
        haz_struct = id_wr_rd && id_rd != '0 && cnt[id_rd] == FULL && !ret[id_rd];
        issue = !reset && id_valid && !id_flush && !(haz1 || haz2 || haz_struct) &&
                ex_ready && pipe_go;
    end

    always_comb begin
        if (id_rs1 == '0)                           op1 = '0;
        else if (cnt[id_rs1] == ONE && ret[id_rs1]) op1 = wb_rdval;
        else                                        op1 = rf_rdata1;
        if (id_rs2 == '0)                           op2 = '0;
        else if (cnt[id_rs2] == ONE && ret[id_rs2]) op2 = wb_rdval;
        else                                        op2 = rf_rdata2;
    end

    always_comb begin
        inc = '0;
        if (issue && id_wr_rd && id_rd != '0) inc[id_rd] = 1'b1;
    end

    // Entry 0 is cleared by reset and never written afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREG; r++) cnt[AW'(r)] <= '0;
        end else begin
            for (int unsigned r = 1; r < NREG; r++) begin
                if (inc[AW'(r)] && !ret[AW'(r)])
                    cnt[AW'(r)] <= cnt[AW'(r)] + ONE;
                else if (ret[AW'(r)] && !inc[AW'(r)] && cnt[AW'(r)] != '0)
                    cnt[AW'(r)] <= cnt[AW'(r)] - ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idex_valid   <= 1'b0;
            idex_rs1_val <= '0;
            idex_rs2_val <= '0;
            idex_rd      <= '0;
            idex_wr_rd   <= 1'b0;
        end else if (pipe_go && ex_ready) begin
            idex_valid <= issue;
            if (issue) begin
                idex_rs1_val <= op1;
                idex_rs2_val <= op2;
                idex_rd      <= id_rd;
                idex_wr_rd   <= id_wr_rd;
            end
        end
    end
endmodule

// File: tb/tb_regread_scoreboard.sv
// Bench for regread_scoreboard: directed vector table for the documented corner
// cases, then randomized traffic checked against a pending-count reference model.
module tb_regread_scoreboard;
    logic        clk = 1'b0;
    logic        reset, pipe_go, id_valid, id_use_rs1, id_use_rs2, id_wr_rd, id_flush;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic        id_ready, wb_active, ex_ready, idex_valid, idex_wr_rd;
    logic [4:0]  rf_raddr1, rf_raddr2, idex_rd;
    logic [63:0] rf_rdata1, rf_rdata2, wb_rdval, idex_rs1_val, idex_rs2_val;

    regread_scoreboard #(.XLEN(64), .AW(5), .CNTW(2)) dut (
        .clk(clk), .reset(reset), .pipe_go(pipe_go), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_wr_rd(id_wr_rd), .id_flush(id_flush), .id_ready(id_ready),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_active(wb_active), .wb_rd(wb_rd), .wb_rdval(wb_rdval), .ex_ready(ex_ready),
        .idex_valid(idex_valid), .idex_rs1_val(idex_rs1_val), .idex_rs2_val(idex_rs2_val),
        .idex_rd(idex_rd), .idex_wr_rd(idex_wr_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rst, go, exr, val, fl;
        int rs1, u1, rs2, u2, rd, wr;
        logic [63:0] rd1, rd2;
        int wba, wbrd;
        logic [63:0] wbv;
        int e_rdy, e_val;
        logic [63:0] e_v1, e_v2;
        int c_reg, c_val;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: number of outstanding writes per register, and the ID/EX contents.
    int          m_cnt [32];
    int          m_valid, m_wr, m_rd;
    logic [63:0] m_v1, m_v2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pending_after(input int r, input int ret_reg);
        if (r == ret_reg && m_cnt[r] > 0) return m_cnt[r] - 1;
        return m_cnt[r];
    endfunction

    function automatic bit src_blocked(input int use_it, input int r, input int ret_reg);
        if (use_it == 0 || r == 0) return 1'b0;
        return pending_after(r, ret_reg) > 0;
    endfunction

    function automatic logic [63:0] operand(input int r, input logic [63:0] rf,
                                            input int ret_reg, input logic [63:0] wbv);
        if (r == 0) return 64'h0;
        if (r == ret_reg && m_cnt[r] == 1) return wbv;
        return rf;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_valid = 0; m_wr = 0; m_rd = 0; m_v1 = '0; m_v2 = '0;
    endtask

    task automatic step(input vec_t s, output logic rdy);
        int ret_reg, inc_reg, d;
        bit blk, m_issue;
        logic [63:0] m_op1, m_op2;
        reset = s.rst != 0;  pipe_go = s.go != 0;  ex_ready = s.exr != 0;
        id_valid = s.val != 0;  id_flush = s.fl != 0;
        id_rs1 = 5'(s.rs1);  id_use_rs1 = s.u1 != 0;
        id_rs2 = 5'(s.rs2);  id_use_rs2 = s.u2 != 0;
        id_rd = 5'(s.rd);  id_wr_rd = s.wr != 0;
        rf_rdata1 = s.rd1;  rf_rdata2 = s.rd2;
        wb_active = s.wba != 0;  wb_rd = 5'(s.wbrd);  wb_rdval = s.wbv;
        #2;
        ret_reg = (s.go != 0 && s.wba != 0 && s.wbrd != 0) ? s.wbrd : -1;
        blk = src_blocked(s.u1, s.rs1, ret_reg) || src_blocked(s.u2, s.rs2, ret_reg) ||
              (s.wr != 0 && s.rd != 0 && pending_after(s.rd, ret_reg) >= 3);
        m_issue = s.rst == 0 && s.val != 0 && s.fl == 0 && !blk && s.exr != 0 && s.go != 0;
        m_op1 = operand(s.rs1, s.rd1, ret_reg, s.wbv);
        m_op2 = operand(s.rs2, s.rd2, ret_reg, s.wbv);
        chk("id_ready", 64'(id_ready), 64'(m_issue));
        chk("rf_raddr1", 64'(rf_raddr1), 64'(s.rs1));
        chk("rf_raddr2", 64'(rf_raddr2), 64'(s.rs2));
        rdy = id_ready;
        @(posedge clk); #1;
        if (s.rst != 0) begin
            model_reset();
        end else if (s.go != 0) begin
            inc_reg = (m_issue && s.wr != 0 && s.rd != 0) ? s.rd : -1;
            for (int r = 1; r < 32; r++) begin
                d = 0;
                if (r == inc_reg) d++;
                if (r == ret_reg) d--;
                if (d < 0 && m_cnt[r] == 0) d = 0;
                m_cnt[r] += d;
            end
            if (s.exr != 0) begin
                m_valid = int'(m_issue);
                if (m_issue) begin
                    m_v1 = m_op1; m_v2 = m_op2; m_rd = s.rd; m_wr = s.wr;
                end
            end
        end
        chk("idex_valid", 64'(idex_valid), 64'(m_valid));
        chk("idex_rs1_val", idex_rs1_val, m_v1);
        chk("idex_rs2_val", idex_rs2_val, m_v2);
        chk("idex_rd", 64'(idex_rd), 64'(m_rd));
        chk("idex_wr_rd", 64'(idex_wr_rd), 64'(m_wr));
    endtask

    vec_t tbl [19];
    vec_t rv;
    logic rdy;
    int   pend [$];

    initial begin
        reset = 1'b1; pipe_go = 1'b0; ex_ready = 1'b0; id_valid = 1'b0; id_flush = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_rd = '0;
        id_wr_rd = 1'b0; rf_rdata1 = '0; rf_rdata2 = '0; wb_active = 1'b0; wb_rd = '0;
        wb_rdval = '0;
        model_reset();

        //          rst go exr val fl rs1 u1 rs2 u2 rd wr  rdata1      rdata2     wba wbrd wbval        rdy vld  exp v1        exp v2     creg cval
        tbl[0]  = '{1, 1, 1, 1, 0, 5, 1, 6, 1, 7, 1, 64'h11,    64'h22,    0, 0,  64'h0,    0, 0, 64'h0,    64'h0,    7, 0};
        tbl[1]  = '{0, 1, 1, 1, 0, 5, 1, 6, 1, 7, 1, 64'h11,    64'h22,    0, 0,  64'h0,    1, 1, 64'h11,   64'h22,   7, 1};
        tbl[2]  = '{0, 1, 1, 1, 0, 7, 1, 0, 0, 0, 0, 64'h99,    64'h0,     0, 0,  64'h0,    0, 0, 64'h11,   64'h22,   7, 1};
        tbl[3]  = '{0, 1, 1, 1, 0, 7, 1, 0, 0, 0, 0, 64'h99,    64'h0,     0, 0,  64'h0,    0, 0, 64'h11,   64'h22,   7, 1};
        tbl[4]  = '{0, 1, 1, 1, 0, 7, 1, 0, 0, 0, 0, 64'h99,    64'h0,     1, 7,  64'hDEAD, 1, 1, 64'hDEAD, 64'h0,    7, 0};
        tbl[5]  = '{0, 1, 1, 1, 0, 0, 1, 3, 1, 0, 1, 64'hFFFF,  64'h33,    0, 0,  64'h0,    1, 1, 64'h0,    64'h33,   0, 0};
        tbl[6]  = '{0, 1, 1, 1, 0, 1, 0, 2, 0, 9, 1, 64'hA1,    64'hA2,    0, 0,  64'h0,    1, 1, 64'hA1,   64'hA2,   9, 1};
        tbl[7]  = '{0, 1, 1, 1, 0, 1, 0, 2, 0, 9, 1, 64'hA1,    64'hA2,    0, 0,  64'h0,    1, 1, 64'hA1,   64'hA2,   9, 2};
        tbl[8]  = '{0, 1, 1, 1, 0, 1, 0, 2, 0, 9, 1, 64'hA1,    64'hA2,    0, 0,  64'h0,    1, 1, 64'hA1,   64'hA2,   9, 3};
        tbl[9]  = '{0, 1, 1, 1, 0, 1, 0, 2, 0, 9, 1, 64'hA1,    64'hA2,    0, 0,  64'h0,    0, 0, 64'hA1,   64'hA2,   9, 3};
        tbl[10] = '{0, 1, 1, 1, 0, 1, 0, 2, 0, 9, 1, 64'hA1,    64'hA2,    1, 9,  64'h55,   1, 1, 64'hA1,   64'hA2,   9, 3};
        tbl[11] = '{0, 1, 1, 1, 0, 1, 0, 2, 0, 7, 1, 64'hB1,    64'hB2,    0, 0,  64'h0,    1, 1, 64'hB1,   64'hB2,   7, 1};
        tbl[12] = '{0, 0, 1, 1, 0, 1, 0, 2, 0, 4, 1, 64'hC1,    64'hC2,    1, 7,  64'h77,   0, 1, 64'hB1,   64'hB2,   7, 1};
        tbl[13] = '{0, 1, 0, 1, 0, 1, 1, 2, 1, 5, 1, 64'hD1,    64'hD2,    0, 0,  64'h0,    0, 1, 64'hB1,   64'hB2,   5, 0};
        tbl[14] = '{0, 1, 0, 1, 0, 1, 1, 2, 1, 5, 1, 64'hD1,    64'hD2,    0, 0,  64'h0,    0, 1, 64'hB1,   64'hB2,   5, 0};
        tbl[15] = '{0, 1, 1, 1, 0, 1, 1, 2, 1, 5, 1, 64'hD1,    64'hD2,    0, 0,  64'h0,    1, 1, 64'hD1,   64'hD2,   5, 1};
        tbl[16] = '{0, 1, 1, 1, 1, 1, 1, 2, 1, 6, 1, 64'hE1,    64'hE2,    0, 0,  64'h0,    0, 0, 64'hD1,   64'hD2,   6, 0};
        tbl[17] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0,     64'h0,     1, 12, 64'h12,   0, 0, 64'hD1,   64'hD2,   12, 0};
        tbl[18] = '{1, 1, 1, 1, 0, 1, 1, 2, 1, 3, 1, 64'hF1,    64'hF2,    1, 9,  64'h9,    0, 0, 64'h0,    64'h0,    9, 0};

        @(posedge clk); #1;
        for (int i = 0; i < 19; i++) begin
            step(tbl[i], rdy);
            chk($sformatf("row%0d id_ready", i), 64'(rdy), 64'(tbl[i].e_rdy));
            chk($sformatf("row%0d idex_valid", i), 64'(idex_valid), 64'(tbl[i].e_val));
            chk($sformatf("row%0d idex_rs1_val", i), idex_rs1_val, tbl[i].e_v1);
            chk($sformatf("row%0d idex_rs2_val", i), idex_rs2_val, tbl[i].e_v2);
            chk($sformatf("row%0d cnt", i), 64'(dut.cnt[tbl[i].c_reg]), 64'(tbl[i].c_val));
        end

        // Random traffic on a small register window so hazards and bypasses are frequent.
        for (int n = 0; n < 800; n++) begin
            rv = '{default: 0, rd1: '0, rd2: '0, wbv: '0, e_v1: '0, e_v2: '0};
            rv.rst = ($urandom_range(0, 149) == 0) ? 1 : 0;
            rv.go  = ($urandom_range(0, 9) != 0) ? 1 : 0;
            rv.exr = ($urandom_range(0, 4) != 0) ? 1 : 0;
            rv.val = ($urandom_range(0, 4) != 0) ? 1 : 0;
            rv.fl  = ($urandom_range(0, 9) == 0) ? 1 : 0;
            rv.rs1 = ($urandom_range(0, 4) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
            rv.rs2 = ($urandom_range(0, 4) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
            rv.u1  = int'($urandom_range(0, 3) != 0);
            rv.u2  = int'($urandom_range(0, 1));
            rv.rd  = int'($urandom_range(0, 7));
            rv.wr  = int'($urandom_range(0, 9) < 7);
            rv.rd1 = {$urandom, $urandom};
            rv.rd2 = {$urandom, $urandom};
            rv.wbv = {$urandom, $urandom};
            pend.delete();
            for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) pend.push_back(r);
            if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
                rv.wba  = 1;
                rv.wbrd = pend[$urandom_range(0, pend.size() - 1)];
            end
            step(rv, rdy);
            if (n % 20 == 19)
                for (int r = 0; r < 32; r++)
                    chk($sformatf("cnt[%0d]", r), 64'(dut.cnt[r]), 64'(m_cnt[r]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
